// File: rtl/jogo_pkg.sv
// Shared encodings for the sequence-memory game control unit.
// The state codes double as the db_estado debug display values, so any
// new state must be given a code that reads sensibly on a hex digit.
package jogo_pkg;

  localparam logic [3:0] ST_INICIAL     = 4'h0;
  localparam logic [3:0] ST_PREPARACAO  = 4'h1;
  localparam logic [3:0] ST_NOVA_SEQ    = 4'h2;
  localparam logic [3:0] ST_ESPERA      = 4'h3;
  localparam logic [3:0] ST_REGISTRA    = 4'h4;
  localparam logic [3:0] ST_COMPARACAO  = 4'h5;
  localparam logic [3:0] ST_PROXIMO     = 4'h6;
  localparam logic [3:0] ST_PERDE_VIDA  = 4'h7;
  localparam logic [3:0] ST_FIM_ACERTO  = 4'hA;
  localparam logic [3:0] ST_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] ST_FIM_ERRO    = 4'hE;

  localparam logic [3:0] DB_INVALIDO    = 4'hF;

  typedef enum logic [3:0] {
    INICIAL     = ST_INICIAL,
    PREPARACAO  = ST_PREPARACAO,
    NOVA_SEQ    = ST_NOVA_SEQ,
    ESPERA      = ST_ESPERA,
    REGISTRA    = ST_REGISTRA,
    COMPARACAO  = ST_COMPARACAO,
    PROXIMO     = ST_PROXIMO,
    PERDE_VIDA  = ST_PERDE_VIDA,
    FIM_ACERTO  = ST_FIM_ACERTO,
    FIM_TIMEOUT = ST_FIM_TIMEOUT,
    FIM_ERRO    = ST_FIM_ERRO
  } estado_t;

  // True for the codes the FSM is allowed to occupy.
  function automatic logic estado_valido(input logic [3:0] s);
    case (s)
      ST_INICIAL, ST_PREPARACAO, ST_NOVA_SEQ, ST_ESPERA, ST_REGISTRA,
      ST_COMPARACAO, ST_PROXIMO, ST_PERDE_VIDA, ST_FIM_ACERTO,
      ST_FIM_TIMEOUT, ST_FIM_ERRO: estado_valido = 1'b1;
      default:                     estado_valido = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/contador_zera_conta.sv
// Purpose: up-counter with synchronous clear (zera) and enable (conta).
// Latency: new value visible one cycle after zera/conta; zera wins over conta.
// Backpressure: none; the caller guarantees it never counts past its range.
// Ports: clock, reset (sync, active-high), zera, conta -> Q[WIDTH-1:0].
module contador_zera_conta #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera,
  input  logic             conta,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      Q <= '0;
    end else if (conta) begin
      Q <= Q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/unidade_controle_jogo_param.sv
// Purpose: control FSM of the sequence-memory game (address, level, timeout, lives).
// Latency: Moore outputs; counter updates visible the cycle after the commanding state.
// Backpressure: none; jogada/jogar are sampled only in the states that use them.
// Ports: clock, reset, jogar, modo, jogada, igual -> endereco, nivel,
//        vidas_restantes, zeraR, registraR, ganhou, perdeu, deu_timeout,
//        pronto, db_estado.
module unidade_controle_jogo_param #(
  parameter int N_MAX          = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int VIDAS          = 3,
  parameter int VIDAS_W        = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               jogar,
  input  logic               modo,
  input  logic               jogada,
  input  logic               igual,
  output logic [ADDR_W-1:0]  endereco,
  output logic [ADDR_W-1:0]  nivel,
  output logic [VIDAS_W-1:0] vidas_restantes,
  output logic               zeraR,
  output logic               registraR,
  output logic               ganhou,
  output logic               perdeu,
  output logic               deu_timeout,
  output logic               pronto,
  output logic [3:0]         db_estado
);
  import jogo_pkg::*;

  localparam int T_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] L_MAX = ADDR_W'(N_MAX - 1);

  estado_t             estado, nxt;
  logic                modo_r;
  logic [ADDR_W-1:0]   e_cnt, l_cnt;
  logic [T_W-1:0]      t_cnt;
  logic                terminal, ultima_vida, estourou;

  assign terminal    = (estado == FIM_ACERTO) || (estado == FIM_ERRO) ||
                       (estado == FIM_TIMEOUT);
  assign ultima_vida = (vidas_restantes == VIDAS_W'(1));
  assign estourou    = (t_cnt == T_W'(TIMEOUT_CYCLES - 1));

  // E: cleared at the start of every round, stepped on each correct play.
  contador_zera_conta #(.WIDTH(ADDR_W)) u_cnt_e (
    .clock (clock),
    .reset (reset),
    .zera  ((estado == PREPARACAO) || (estado == NOVA_SEQ) || (estado == PERDE_VIDA)),
    .conta (estado == PROXIMO),
    .Q     (e_cnt)
  );

  // L: progressive level counter. Fixed mode never reaches nova_seq (its
  // first round already ends at L_MAX), so the level is substituted by
  // the constant instead of loading the counter.
  contador_zera_conta #(.WIDTH(ADDR_W)) u_cnt_l (
    .clock (clock),
    .reset (reset),
    .zera  (estado == PREPARACAO),
    .conta (estado == NOVA_SEQ),
    .Q     (l_cnt)
  );

  // T: runs only while waiting, so every espera visit starts from zero.
  contador_zera_conta #(.WIDTH(T_W)) u_cnt_t (
    .clock (clock),
    .reset (reset),
    .zera  (estado != ESPERA),
    .conta (estado == ESPERA),
    .Q     (t_cnt)
  );

  assign endereco  = e_cnt;
  assign nivel     = modo_r ? L_MAX : l_cnt;
  assign db_estado = estado_valido(estado) ? estado : DB_INVALIDO;

  always_comb begin
    nxt = estado;
    case (estado)
      INICIAL:                       if (jogar) nxt = PREPARACAO;
      PREPARACAO:                    nxt = ESPERA;
      NOVA_SEQ, PROXIMO, PERDE_VIDA: nxt = ESPERA;
      ESPERA: begin
        // A play on the last allowed cycle beats the timeout.
        if (jogada)        nxt = REGISTRA;
        else if (estourou) nxt = ultima_vida ? FIM_TIMEOUT : PERDE_VIDA;
      end
      REGISTRA:                      nxt = COMPARACAO;
      COMPARACAO: begin
        if (!igual)              nxt = ultima_vida ? FIM_ERRO : PERDE_VIDA;
        else if (e_cnt < nivel)  nxt = PROXIMO;
        else if (nivel == L_MAX) nxt = FIM_ACERTO;
        else                     nxt = NOVA_SEQ;
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (jogar) nxt = PREPARACAO;
      default:                       nxt = INICIAL;
    endcase
  end

  // Flags are registered from the next state so they line up with estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= INICIAL;
      modo_r          <= 1'b0;
      vidas_restantes <= '0;
      zeraR           <= 1'b1;
      registraR       <= 1'b0;
      ganhou          <= 1'b0;
      perdeu          <= 1'b0;
      deu_timeout     <= 1'b0;
      pronto          <= 1'b0;
    end else begin
      estado <= nxt;
      if ((estado == INICIAL || terminal) && jogar) modo_r <= modo;
      if (estado == PREPARACAO)      vidas_restantes <= VIDAS_W'(VIDAS);
      else if (estado == PERDE_VIDA) vidas_restantes <= vidas_restantes - VIDAS_W'(1);
      zeraR       <= (nxt == INICIAL);
      registraR   <= (nxt == REGISTRA);
      ganhou      <= (nxt == FIM_ACERTO);
      perdeu      <= (nxt == FIM_ERRO) || (nxt == FIM_TIMEOUT);
      deu_timeout <= (nxt == FIM_TIMEOUT);
      pronto      <= (nxt == FIM_ACERTO) || (nxt == FIM_ERRO) || (nxt == FIM_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_unidade_controle_jogo_param.sv
// Purpose: directed self-checking bench for the game control unit.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: n/a.
module tb_unidade_controle_jogo_param;

  logic       clock, reset, jogar, modo, jogada, igual;
  logic [3:0] endereco, nivel, db_estado;
  logic [1:0] vidas_restantes;
  logic       zeraR, registraR, ganhou, perdeu, deu_timeout, pronto;

  int n_chk, n_pass, n_registra, n_prep;

  unidade_controle_jogo_param #(
    .N_MAX(4), .ADDR_W(4), .TIMEOUT_CYCLES(8), .VIDAS(2), .VIDAS_W(2)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .modo(modo),
    .jogada(jogada), .igual(igual), .endereco(endereco), .nivel(nivel),
    .vidas_restantes(vidas_restantes), .zeraR(zeraR), .registraR(registraR),
    .ganhou(ganhou), .perdeu(perdeu), .deu_timeout(deu_timeout),
    .pronto(pronto), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start a game from inicial or a terminal state; ends in espera.
  task automatic start(input logic m);
    modo = m; jogar = 1'b1;
    tick();
    check("start_prep_db", db_estado, 4'h1);
    jogar = 1'b0;
    tick();
    check("start_espera_db", db_estado, 4'h3);
    check("start_vidas", vidas_restantes, 2);
    check("start_nivel", nivel, m ? 3 : 0);
    check("start_endereco", endereco, 0);
  endtask

  // One play from espera; ends in the state following comparacao.
  task automatic play(input logic ig);
    jogada = 1'b1; igual = ig;
    tick();
    check("play_registra_db", db_estado, 4'h4);
    check("play_registraR", registraR, 1);
    if (db_estado == 4'h4) n_registra++;
    jogada = 1'b0;
    tick();
    check("play_comparacao_db", db_estado, 4'h5);
    tick();
    igual = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_registra = 0; n_prep = 0;
    reset = 1'b1; jogar = 1'b0; modo = 1'b0; jogada = 1'b0; igual = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_db", db_estado, 4'h0);
    check("rst_zeraR", zeraR, 1);
    check("rst_vidas", vidas_restantes, 0);
    check("rst_pronto", pronto, 0);

    // Reset in the middle of a game.
    start(1'b0);
    play(1'b1);
    check("lvl1_nova_seq_db", db_estado, 4'h2);
    tick();
    check("lvl2_nivel", nivel, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_db", db_estado, 4'h0);
    check("midrst_endereco", endereco, 0);
    check("midrst_nivel", nivel, 0);
    check("midrst_vidas", vidas_restantes, 0);
    check("midrst_zeraR", zeraR, 1);

    // Progressive win: 1+2+3+4 = 10 correct plays.
    start(1'b0);
    for (int lv = 0; lv < 4; lv++) begin
      for (int a = 0; a <= lv; a++) begin
        check("prog_endereco", endereco, a);
        check("prog_nivel", nivel, lv);
        play(1'b1);
        tick();
      end
    end
    check("prog_win_db", db_estado, 4'hA);
    check("prog_ganhou", ganhou, 1);
    check("prog_pronto", pronto, 1);
    check("prog_perdeu", perdeu, 0);
    check("prog_nivel_final", nivel, 3);
    check("prog_vidas_final", vidas_restantes, 2);

    // Fixed mode: one round of 4 plays at the last level.
    n_registra = 0;
    start(1'b1);
    for (int a = 0; a < 4; a++) begin
      check("fix_endereco", endereco, a);
      play(1'b1);
      check("fix_after_play_db", db_estado, (a == 3) ? 4'hA : 4'h6);
      tick();
    end
    check("fix_win_db", db_estado, 4'hA);
    check("fix_registra_visits", n_registra, 4);
    check("fix_ganhou", ganhou, 1);

    // Errors: lose a life at level 2, then lose the game.
    start(1'b0);
    play(1'b1);
    tick();
    play(1'b1);
    check("err_proximo_db", db_estado, 4'h6);
    tick();
    check("err_endereco1", endereco, 1);
    play(1'b0);
    check("err_perde_vida_db", db_estado, 4'h7);
    tick();
    check("err_espera_db", db_estado, 4'h3);
    check("err_vidas", vidas_restantes, 1);
    check("err_endereco0", endereco, 0);
    check("err_nivel", nivel, 1);
    play(1'b0);
    check("err_fim_db", db_estado, 4'hE);
    check("err_perdeu", perdeu, 1);
    check("err_deu_timeout", deu_timeout, 0);
    check("err_pronto", pronto, 1);
    check("err_ganhou", ganhou, 0);

    // jogar held for three cycles in a terminal state restarts once.
    modo = 1'b0; jogar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (db_estado == 4'h1) n_prep++;
    end
    jogar = 1'b0;
    check("hold_prep_once", n_prep, 1);
    check("hold_db", db_estado, 4'h3);
    check("hold_vidas", vidas_restantes, 2);
    check("hold_nivel", nivel, 0);

    // Timeouts: 8 idle cycles in espera cost a life, then end the game.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start(1'b0);
    repeat (7) tick();
    check("to1_still_espera", db_estado, 4'h3);
    tick();
    check("to1_perde_vida", db_estado, 4'h7);
    tick();
    check("to1_vidas", vidas_restantes, 1);
    repeat (7) tick();
    check("to2_still_espera", db_estado, 4'h3);
    tick();
    check("to2_fim_db", db_estado, 4'hD);
    check("to2_deu_timeout", deu_timeout, 1);
    check("to2_perdeu", perdeu, 1);
    check("to2_pronto", pronto, 1);
    check("to2_ganhou", ganhou, 0);

    // Play on the 8th cycle beats the timeout.
    start(1'b0);
    repeat (7) tick();
    jogada = 1'b1;
    tick();
    check("to_edge_registra", db_estado, 4'h4);
    jogada = 1'b0; igual = 1'b1;
    tick();
    check("to_edge_comparacao", db_estado, 4'h5);
    tick();
    check("to_edge_nova_seq", db_estado, 4'h2);
    igual = 1'b0;
    tick();
    check("to_edge_espera", db_estado, 4'h3);
    check("to_edge_nivel", nivel, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
